// File: rtl/vedic_pkg.sv
// Shared types and sizing helpers for the sequential Vedic multiplier.
package vedic_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // A column holds at most `width` partial products plus a carry below `width`,
  // so two extra bits over clog2(width) always cover the column total.
  function automatic int cw_of(input int width);
    return $clog2(width) + 2;
  endfunction

endpackage

// File: rtl/vedic_column_sum.sv
// Combinational crosswise column: counts a_r[i]&b_r[j] over all i+j == col.
import vedic_pkg::*;

module vedic_column_sum #(
  parameter int WIDTH = 8,
  parameter int CW    = cw_of(WIDTH),
  parameter int CIW   = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] a_r,
  input  logic [WIDTH-1:0] b_r,
  input  logic [CIW-1:0]   col,
  output logic [CW-1:0]    sum
);

  logic [WIDTH-1:0] pp;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic bj;

    // Partner bit b_r[col-i]; zero when that index falls outside the operand.
    always_comb begin
      bj = 1'b0;
      for (int k = 0; k < WIDTH; k++)
        if (i + k == int'(col)) bj = b_r[k];
    end

    // AND built purely from NOR: NOR(NOR(x,x), NOR(y,y)).
    assign pp[i] = ~(~(a_r[i] | a_r[i]) | ~(bj | bj));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < WIDTH; i++)
      sum = sum + CW'(pp[i]);
  end

endmodule

// File: rtl/vedic_mult_seq.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier, one Urdhva-Tiryagbhyam column per clock.
import vedic_pkg::*;

module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW  = cw_of(WIDTH);
  localparam int CIW = $clog2(2*WIDTH);
  localparam logic [CIW-1:0] LAST = CIW'(2*WIDTH-2);

  state_e           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    carry, col_sum, s;
  logic [CIW-1:0]   col;

  vedic_column_sum #(.WIDTH(WIDTH), .CW(CW), .CIW(CIW)) u_col (
    .a_r (a_r),
    .b_r (b_r),
    .col (col),
    .sum (col_sum)
  );

  assign s         = col_sum + carry;
  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry   <= '0;
      col     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          carry   <= '0;
          col     <= '0;
          product <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          product[col] <= s[0];
          carry        <= {1'b0, s[CW-1:1]};
          col          <= col + 1'b1;
          // Final column: the leftover carry is a single bit and becomes the MSB.
          if (col == LAST) begin
            product[col + 1'b1] <= s[1];
            state               <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against a plain a*b model.
module tb_vedic_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, b;
  logic        iv4, iv8, or4, or8;
  logic        ir4, ir8, ov4, ov8, bs4, bs8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a[3:0]), .b(b[3:0]),
    .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bs4)
  );

  vedic_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bs8)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rdy(input int d);  return d ? longint'(ir8) : longint'(ir4); endfunction
  function automatic longint outv(input int d); return d ? longint'(ov8) : longint'(ov4); endfunction
  function automatic longint bsy(input int d);  return d ? longint'(bs8) : longint'(bs4); endfunction
  function automatic longint prod(input int d); return d ? longint'(p8)  : longint'(p4);  endfunction

  task automatic set_iv(input int d, input logic v);
    if (d != 0) iv8 = v; else iv4 = v;
  endtask

  task automatic set_or(input int d, input logic v);
    if (d != 0) or8 = v; else or4 = v;
  endtask

  // One transaction; d selects the instance (0: WIDTH=4, 1: WIDTH=8).
  // stall = DONE cycles with out_ready low; noisy = drive in_valid a=1,b=1 while busy.
  task automatic txn(input int d, input int av, input int bv, input int stall,
                     input bit noisy, input string tag);
    int     w   = (d != 0) ? 8 : 4;
    int     lat = 2*w - 1;
    longint exp = longint'(av) * longint'(bv);
    int     cyc = 0;
    chk({tag, ".idle_ready"}, rdy(d), 1);
    a = 8'(av); b = 8'(bv);
    set_iv(d, 1'b1);
    set_or(d, stall == 0);
    step();
    // Operands change right after acceptance; the latched copy must be used.
    if (noisy) begin a = 8'd1; b = 8'd1; end
    else begin set_iv(d, 1'b0); a = 8'($urandom); b = 8'($urandom); end
    chk({tag, ".busy"}, bsy(d), 1);
    chk({tag, ".busy_not_ready"}, rdy(d), 0);
    while (outv(d) == 0 && cyc < 200) begin
      step();
      cyc++;
    end
    set_iv(d, 1'b0);
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".product"}, prod(d), exp);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({tag, ".hold_valid"}, outv(d), 1);
      chk({tag, ".hold_product"}, prod(d), exp);
    end
    set_or(d, 1'b1);
    step();
    set_or(d, 1'b0);
    chk({tag, ".ready_after"}, rdy(d), 1);
    chk({tag, ".valid_after"}, outv(d), 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b0; or8 = 1'b0;
    a = '0; b = '0;
    #12;
    chk("rst.in_ready", ir4, 1);
    chk("rst.out_valid", ov4, 0);
    chk("rst.busy", bs4, 0);
    chk("rst.product4", p4, 0);
    chk("rst.product8", p8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    txn(0, 13, 11, 0, 1'b0, "w4_13x11");
    txn(0, 15, 15, 0, 1'b0, "w4_15x15");
    txn(0, 0, 9, 0, 1'b0, "w4_0x9");
    txn(1, 255, 255, 0, 1'b0, "w8_255x255");
    txn(1, 200, 3, 0, 1'b0, "w8_200x3");
    txn(0, 6, 7, 5, 1'b1, "w4_stall_6x7");
    txn(0, 3, 5, 0, 1'b0, "w4_after_stall");

    // Reset three cycles into BUSY discards the in-flight product.
    a = 8'd9; b = 8'd9; iv4 = 1'b1; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", ir4, 1);
    chk("midrst.out_valid", ov4, 0);
    chk("midrst.busy", bs4, 0);
    chk("midrst.product", p4, 0);
    step();
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (ov4) seen++;
    end
    chk("midrst.no_valid", seen, 0);
    or4 = 1'b0;
    txn(0, 5, 5, 0, 1'b0, "w4_post_rst_5x5");

    for (int n = 0; n < 200; n++)
      txn(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 3)), 1'b0, "w8_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
